// File: rtl/sim_ram_ctrl_if.sv
// rtl/sim_ram_ctrl_if.sv - command/response bus between a requester and sim_ram_ctrl
// Parameters: DW data width (multiple of 8), AW word-address width.
// Command channel : cmd_valid, cmd_ready, cmd_read, cmd_addr, cmd_wdata, cmd_wmask
// Response channel: rsp_valid, rsp_ready, rsp_rdata, rsp_err
// Modports: master (requester side), slave (memory side).
interface sim_ram_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_read;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sim_ram_ctrl.sv
// rtl/sim_ram_ctrl.sv - word-addressed RAM with valid/ready command and in-order response channels
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset of all control state (array contents kept)
//   bus  - sim_ram_ctrl_if.slave: command in (read/write, addr, wdata, byte mask),
//          response out (rdata, err), both valid/ready
// Parameters: DP depth (power of two), DW data width, AW address width,
//   RD_LAT accept-to-response latency (1..4), RSP_DEPTH max outstanding commands.
// Optional macro SIM_RAM_CTRL_X2ZERO_EN: X/Z bits read from the array become 0
//   (simulation only; synthesis builds always pass raw data).
module sim_ram_ctrl #(
  parameter int DP        = 512,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  sim_ram_ctrl_if.slave bus
);
  localparam int IW = $clog2(DP);
  localparam int MW = DW / 8;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DW-1:0] mem_q [DP];

  logic [IW-1:0] idx;
  logic          oor;
  logic          acc;
  logic          pop;
  logic          head_valid;
  logic [DW-1:0] rd_raw;
  logic [DW-1:0] rd_clean;
  logic [DW-1:0] in_data;

  logic          push;
  logic          push_err;
  logic [DW-1:0] push_data;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fifo_err_q  [RSP_DEPTH];
  logic [DW-1:0] fifo_data_q [RSP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign idx = bus.cmd_addr[IW-1:0];

  generate
    if (AW > IW) begin : g_oor
      assign oor = |bus.cmd_addr[AW-1:IW];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  // Occupancy counts everything accepted and not yet popped, so readiness
  // never looks at rsp_ready in the same cycle.
  assign bus.cmd_ready = !rst && (cnt_q < CW'(RSP_DEPTH));
  assign acc           = bus.cmd_valid && bus.cmd_ready;
  assign head_valid    = (fcnt_q != '0);
  assign pop           = head_valid && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (acc && !bus.cmd_read && !oor) begin
      for (int i = 0; i < MW; i++) begin
        if (bus.cmd_wmask[i]) mem_q[idx][8*i +: 8] <= bus.cmd_wdata[8*i +: 8];
      end
    end
  end

  assign rd_raw = mem_q[idx];

`ifdef SIM_RAM_CTRL_X2ZERO_EN
`ifndef SYNTHESIS
  always_comb begin
    rd_clean = '0;
    for (int b = 0; b < DW; b++) rd_clean[b] = (rd_raw[b] === 1'b1);
  end
`else
  assign rd_clean = rd_raw;
`endif
`else
  assign rd_clean = rd_raw;
`endif

  // Writes and errors respond with zero data.
  assign in_data = (bus.cmd_read && !oor) ? rd_clean : '0;

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign push      = acc;
      assign push_err  = oor;
      assign push_data = in_data;
    end else begin : g_pipe
      logic          stg_v_q [RD_LAT-1];
      logic          stg_e_q [RD_LAT-1];
      logic [DW-1:0] stg_d_q [RD_LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < RD_LAT - 1; s++) begin
            stg_v_q[s] <= 1'b0;
            stg_e_q[s] <= 1'b0;
            stg_d_q[s] <= '0;
          end
        end else begin
          stg_v_q[0] <= acc;
          stg_e_q[0] <= oor;
          stg_d_q[0] <= in_data;
          for (int s = 1; s < RD_LAT - 1; s++) begin
            stg_v_q[s] <= stg_v_q[s-1];
            stg_e_q[s] <= stg_e_q[s-1];
            stg_d_q[s] <= stg_d_q[s-1];
          end
        end
      end

      assign push      = stg_v_q[RD_LAT-2];
      assign push_err  = stg_e_q[RD_LAT-2];
      assign push_data = stg_d_q[RD_LAT-2];
    end
  endgenerate

  always_comb begin
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (acc && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!acc && pop) cnt_d = cnt_q - CW'(1);
    if (push && !pop)      fcnt_d = fcnt_q + CW'(1);
    else if (!push && pop) fcnt_d = fcnt_q - CW'(1);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_err_q[i]  <= 1'b0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        fifo_err_q[wr_ptr_q]  <= push_err;
        fifo_data_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign bus.rsp_valid = head_valid;
  assign bus.rsp_rdata = head_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.rsp_err   = head_valid ? fifo_err_q[rd_ptr_q] : 1'b0;
endmodule

// File: doc/sim_ram_ctrl.md
Name: sim_ram_ctrl

Overview:
- Parametrised successor to the plain simulation SRAM model; used as ITCM/DTCM backing store.
- Adds a valid/ready command channel and a valid/ready response channel.
- Adds configurable read latency, an in-order response buffer with backpressure, out-of-range error reporting and asynchronous reset of all control state.
- Sits between the core's load/store or fetch unit and the memory array.

Parameters:
- DP, 512: depth in words; power of two, >= 2.
- DW, 32: data width; multiple of 8. Mask width MW = DW/8.
- AW, 32: command address width, as a word index.
- RD_LAT, 1: cycles from command acceptance to earliest response; legal 1..4.
- RSP_DEPTH, 2: maximum commands outstanding (in pipeline plus response buffer); >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted.
- cmd_read  in  1  1 = read, 0 = write.
- cmd_addr  in  AW  word index.
- cmd_wdata  in  DW  write data.
- cmd_wmask  in  DW/8  byte write enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.

Behaviour:
- Reset: asynchronous, active-high; the polarity and synchronicity are fixed.
  - While rst is high: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The latency pipeline and response buffer are cleared; in-flight commands are discarded with no response.
  - Array contents are not reset; a write accepted before reset stays committed.
- Accept: a command is accepted on a rising edge where cmd_valid && cmd_ready.
- cmd_ready = !rst && (inflight + buffered) < RSP_DEPTH.
  - The count includes a response being popped in the same cycle, so the occupancy check is conservative: no combinational path from rsp_ready.
- Addressing: index = cmd_addr[log2(DP)-1:0]. If any of cmd_addr[AW-1:log2(DP)] is nonzero, the address is out of range:
  - no write is performed;
  - the response carries rsp_err=1 and rsp_rdata=0.
- Write: bytes with cmd_wmask[i]=1 are written on the accept edge; other bytes are unchanged. wmask=0 is a legal no-op that still produces a response.
- Read: data is sampled from the array on the accept edge and carried down the latency pipeline.
  - A write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Latency: the command is accepted at edge T. With the buffer empty, rsp_valid rises after edge T+RD_LAT-1, and the response is consumable at edge T+RD_LAT.
  - RD_LAT=1 therefore gives a response in the cycle after acceptance.
- Pipeline: RD_LAT-1 register stages of {valid, err, data}. The last stage pushes into a RSP_DEPTH-entry FIFO whose head drives the rsp_* outputs.
  - The FIFO never overflows because of the cmd_ready rule.
- Ordering: responses are strictly in command order, one per accepted command, including writes.
- Response handshake: the head is popped on an edge where rsp_valid && rsp_ready.
  - While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err hold stable.
- Simultaneous push and pop on the same edge: occupancy is unchanged and the head advances.
- Full: with RSP_DEPTH outstanding, cmd_ready=0 until a pop edge. cmd_ready rises in the cycle after that pop, giving full throughput of one command per cycle when RSP_DEPTH >= RD_LAT+1.
- Empty: rsp_valid=0; rsp_rdata and rsp_err are driven 0.
- Pointers wrap modulo RSP_DEPTH.
- Occupancy counter width is clog2(RSP_DEPTH+1).

Optional Feature:
- Macro: SIM_RAM_CTRL_X2ZERO_EN.
- Defined: any read-data bit that is X or Z when sampled from the array is converted to 0 before entering the pipeline. This is the simulation-only path, guarded additionally by `ifndef SYNTHESIS`.
- Undefined: raw array bits propagate unchanged, so reads of unwritten words return X.

Test Plan:
- Reset then write: reset, write addr 5 data 0xDEADBEEF mask 0xF, then read addr 5 with RD_LAT=1 -> write response err=0 rdata=0; read response next cycle with rdata=0xDEADBEEF.
- Byte mask: write 0x11223344 mask 0xF to addr 7, then 0xAABBCCDD mask 0x5, then read addr 7 -> rdata=0x11BB33DD.
- Out of range: DP=512, read and write addr 0x200 -> rsp_err=1, rdata=0; a subsequent read of addr 0 shows it unmodified.
- Backpressure: RSP_DEPTH=2, RD_LAT=2, rsp_ready=0, issue 3 back-to-back reads -> cmd_ready=0 after 2 accepts; rsp_rdata holds stable; raise rsp_ready -> 3 responses in order, third accepted the cycle after the first pop.
- Throughput: RSP_DEPTH=3, RD_LAT=2, rsp_ready=1, 10 consecutive reads -> cmd_ready stays 1; responses appear on 10 consecutive cycles starting 2 cycles after the first accept.
- Reset mid-operation: 2 reads in flight and 1 buffered, assert rst asynchronously -> rsp_valid=0 immediately; no stale response after release; an earlier committed write is still readable.
